// File: rtl/decode_pkg.sv
// decode_pkg: instruction word layout shared by the encoder, the decoder and
// the benches. Holds the opcode encodings, field bit positions and a packed
// struct whose member order matches the 32-bit word from MSB to LSB.
package decode_pkg;

  typedef enum logic [1:0] {
    OP_DP      = 2'b00,
    OP_MEM     = 2'b01,
    OP_BR      = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  localparam int unsigned COND_HI  = 31;
  localparam int unsigned COND_LO  = 28;
  localparam int unsigned OP_HI    = 27;
  localparam int unsigned OP_LO    = 26;
  localparam int unsigned FUNCT_HI = 25;
  localparam int unsigned FUNCT_LO = 20;
  localparam int unsigned RN_HI    = 19;
  localparam int unsigned RN_LO    = 16;
  localparam int unsigned RD_HI    = 15;
  localparam int unsigned RD_LO    = 12;
  localparam int unsigned SRC2_HI  = 11;
  localparam int unsigned SRC2_LO  = 0;

  typedef struct packed {
    logic [3:0]  cond;
    op_e         op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
  } instr_fields_t;

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: show-ahead synchronous FIFO with asynchronous active-high reset.
//   clk, rst       : clock, async reset
//   push, din      : write din at tail (ignored when full)
//   pop            : drop head entry (ignored when empty)
//   dout           : head entry; holds its last value while empty
//   full, empty    : occupancy flags
//   level          : current occupancy, 0..DEPTH
module instr_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [LW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_head;

  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rd_next;
  logic [LW-1:0]    w_cnt_next;

  assign full  = (r_cnt == LW'(DEPTH));
  assign empty = (r_cnt == '0);
  assign level = r_cnt;
  assign dout  = r_head;

  assign w_push     = push & ~full;
  assign w_pop      = pop & ~empty;
  assign w_rd_next  = r_rd + AW'(w_pop);
  assign w_cnt_next = r_cnt + LW'(w_push) - LW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  // The head is registered so it can hold its value while empty. When the
  // next head slot is the one being written this cycle, take din directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_head <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      r_rd  <= w_rd_next;
      r_cnt <= w_cnt_next;
      if (w_cnt_next != '0)
        r_head <= (w_push && (r_wr == w_rd_next)) ? din : r_mem[w_rd_next];
    end
  end

endmodule

// File: rtl/instr_encoder_queue.sv
// instr_encoder_queue: packs decoded fields into instruction words, drops
// illegal opcodes and queues legal words for in-order delivery.
//   clk, reset                 : clock, async active-high reset
//   enc_valid/enc_ready        : request handshake; fields cond/op/funct/rn/rd/src2
//   instr_valid/instr_ready    : output handshake; instr_out is the head word
//   fill_level                 : queue occupancy
//   illegal_pulse              : one cycle after an illegal request is dropped
//   err_count, issued_count    : saturating dropped / delivered counters
module instr_encoder_queue
  import decode_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enc_valid,
  output logic                   enc_ready,
  input  logic [3:0]             cond,
  input  logic [1:0]             op,
  input  logic [5:0]             funct,
  input  logic [3:0]             rn,
  input  logic [3:0]             rd,
  input  logic [11:0]            src2,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [WIDTH-1:0]       instr_out,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   illegal_pulse,
  output logic [CNT_W-1:0]       err_count,
  output logic [CNT_W-1:0]       issued_count
);

  logic [WIDTH-1:0] w_word;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_illegal;
  logic             w_push;
  logic             w_pop;

  logic             r_illegal;
  logic [CNT_W-1:0] r_err;
  logic [CNT_W-1:0] r_issued;

  always_comb begin
    w_word                    = '0;
    w_word[COND_HI:COND_LO]   = cond;
    w_word[OP_HI:OP_LO]       = op;
    w_word[FUNCT_HI:FUNCT_LO] = funct;
    w_word[RN_HI:RN_LO]       = rn;
    w_word[RD_HI:RD_LO]       = rd;
    w_word[SRC2_HI:SRC2_LO]   = src2;
  end

  assign enc_ready   = ~w_full;
  assign instr_valid = ~w_empty;

  assign w_accept  = enc_valid & enc_ready;
  assign w_illegal = w_accept & (op == OP_ILLEGAL);
  assign w_push    = w_accept & (op != OP_ILLEGAL);
  assign w_pop     = instr_valid & instr_ready;

  instr_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (reset),
    .push (w_push),
    .pop  (w_pop),
    .din  (w_word),
    .dout (instr_out),
    .full (w_full),
    .empty(w_empty),
    .level(fill_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal <= 1'b0;
      r_err     <= '0;
      r_issued  <= '0;
    end else begin
      r_illegal <= w_illegal;
      if (w_illegal && (r_err != '1)) r_err <= r_err + CNT_W'(1);
      if (w_pop && (r_issued != '1))  r_issued <= r_issued + CNT_W'(1);
    end
  end

  assign illegal_pulse = r_illegal;
  assign err_count     = r_err;
  assign issued_count  = r_issued;

endmodule

// File: tb/tb_instr_encoder_queue.sv
module tb_instr_encoder_queue;
  import decode_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enc_valid, enc_ready;
  logic [3:0]  cond, rn, rd;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [11:0] src2;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_out;
  logic [2:0]  fill_level;
  logic        illegal_pulse;
  logic [7:0]  err_count, issued_count;

  instr_encoder_queue #(.WIDTH(32), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enc_valid(enc_valid), .enc_ready(enc_ready),
    .cond(cond), .op(op), .funct(funct), .rn(rn), .rd(rd), .src2(src2),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .fill_level(fill_level), .illegal_pulse(illegal_pulse),
    .err_count(err_count), .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0, n_total = 0;

  // Reference model: a queue of words plus counters.
  logic [31:0] m_q[$];
  logic [31:0] m_out;
  logic        m_pulse;
  logic [7:0]  m_err, m_iss;

  // DUT head word captured just before an edge on which a pop happens.
  logic        g_popped;
  logic [31:0] g_pop_word;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_out = '0; m_pulse = 1'b0; m_err = '0; m_iss = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".enc_ready"},   32'(enc_ready),     32'(m_q.size() != DEPTH));
    chk({tag, ".instr_valid"}, 32'(instr_valid),   32'(m_q.size() != 0));
    chk({tag, ".instr_out"},   instr_out,          m_out);
    chk({tag, ".fill_level"},  32'(fill_level),    32'(m_q.size()));
    chk({tag, ".illegal"},     32'(illegal_pulse), 32'(m_pulse));
    chk({tag, ".err_count"},   32'(err_count),     32'(m_err));
    chk({tag, ".issued"},      32'(issued_count),  32'(m_iss));
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] f, input logic [3:0] n, input logic [3:0] d,
                       input logic [11:0] s, input logic r, input string tag);
    logic acc, pop;
    logic [31:0] w;
    enc_valid = v; cond = c; op = o; funct = f; rn = n; rd = d; src2 = s;
    instr_ready = r;
    acc = v && (m_q.size() < DEPTH);
    pop = r && (m_q.size() != 0);
    w = {c, o, f, n, d, s};
    g_popped = instr_valid && instr_ready;
    g_pop_word = instr_out;
    @(posedge clk); #1;
    if (pop) begin
      void'(m_q.pop_front());
      if (m_iss != 8'hFF) m_iss++;
    end
    m_pulse = 1'b0;
    if (acc) begin
      if (o == 2'b11) begin
        m_pulse = 1'b1;
        if (m_err != 8'hFF) m_err++;
      end else m_q.push_back(w);
    end
    if (m_q.size() != 0) m_out = m_q[0];
    check_all(tag);
  endtask

  task automatic idle(input logic r, input string tag);
    drive(1'b0, 4'h0, 2'b00, 6'h0, 4'h0, 4'h0, 12'h0, r, tag);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] c; logic [1:0] o; logic [5:0] f;
    logic [3:0] n; logic [3:0] d; logic [11:0] s; logic [31:0] exp;
  } vec_t;
  vec_t vecs[4];

  logic [3:0]  exp_rd[6];
  logic [3:0]  got_rd[$];
  logic [11:0] got_s[$];

  initial begin
    vecs[0] = '{4'hE, 2'b00, 6'b101000, 4'h1, 4'h2, 12'h005, 32'hE2812005};
    vecs[1] = '{4'h0, 2'b01, 6'h00,     4'h0, 4'h0, 12'h000, 32'h04000000};
    vecs[2] = '{4'hF, 2'b10, 6'h3F,     4'hF, 4'hF, 12'hFFF, 32'hFBFFFFFF};
    vecs[3] = '{4'h1, 2'b01, 6'h01,     4'h3, 4'h4, 12'hABC, 32'h14134ABC};
    exp_rd = '{4'hA, 4'hB, 4'h0, 4'h1, 4'h2, 4'h3};

    reset = 1'b1; enc_valid = 0; instr_ready = 0;
    cond = 0; op = 0; funct = 0; rn = 0; rd = 0; src2 = 0;
    model_reset();
    #1 check_all("por");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Packing table
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vecs[i].c, vecs[i].o, vecs[i].f, vecs[i].n, vecs[i].d, vecs[i].s, 1'b0, "pack");
      chk("pack.word", instr_out, vecs[i].exp);
      chk("pack.level", 32'(fill_level), 32'd1);
      idle(1'b1, "pack.pop");
    end

    // Fill and stall
    hard_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'hE, 2'b00, 6'h0, 4'h1, 4'(i), 12'h0, 1'b0, "fill");
      if (i == 3) chk("fill.ready_low", 32'(enc_ready), 32'd0);
    end
    chk("fill.level4", 32'(fill_level), 32'd4);
    drive(1'b1, 4'hE, 2'b00, 6'h0, 4'h1, 4'h4, 12'h0, 1'b1, "stall.pop1");
    drive(1'b1, 4'hE, 2'b00, 6'h0, 4'h1, 4'h4, 12'h0, 1'b1, "stall.acc5");
    got_rd.delete();
    for (int i = 0; i < 10 && instr_valid; i++) begin
      idle(1'b1, "drain");
      got_rd.push_back(g_pop_word[15:12]);
    end
    chk("drain.issued", 32'(issued_count), 32'd5);
    chk("drain.popcnt", 32'(got_rd.size()), 32'd3);

    // Illegal op
    hard_reset();
    drive(1'b1, 4'h0, 2'b11, 6'h0, 4'h0, 4'h0, 12'h0, 1'b0, "ill");
    chk("ill.pulse", 32'(illegal_pulse), 32'd1);
    chk("ill.err1", 32'(err_count), 32'd1);
    chk("ill.valid", 32'(instr_valid), 32'd0);
    idle(1'b0, "ill.after");
    chk("ill.pulse_gone", 32'(illegal_pulse), 32'd0);
    hard_reset();
    for (int i = 0; i < 256; i++)
      drive(1'b1, 4'h3, 2'b11, 6'h5, 4'h0, 4'h0, 12'(i), 1'b0, "illsat");
    chk("ill.sat", 32'(err_count), 32'hFF);

    // Simultaneous push/pop at level 2
    hard_reset();
    drive(1'b1, 4'h0, 2'b00, 6'h0, 4'h0, 4'hA, 12'h0, 1'b0, "pre");
    drive(1'b1, 4'h0, 2'b00, 6'h0, 4'h0, 4'hB, 12'h0, 1'b0, "pre");
    got_rd.delete();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'h0, 2'b01, 6'h0, 4'h0, 4'(i), 12'h0, 1'b1, "pp");
      if (g_popped) got_rd.push_back(g_pop_word[15:12]);
      chk("pp.level", 32'(fill_level), 32'd2);
    end
    chk("pp.count", 32'(got_rd.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_rd.size(); i++)
      chk("pp.order", 32'(got_rd[i]), 32'(exp_rd[i]));

    // Wrap-around
    hard_reset();
    drive(1'b1, 4'h0, 2'b10, 6'h0, 4'h0, 4'h0, 12'd0, 1'b0, "wrap.pre");
    got_s.delete();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive(1'b1, 4'h0, 2'b10, 6'h0, 4'h0, 4'h0, 12'(i + 1), 1'b1, "wrap");
      if (g_popped) got_s.push_back(g_pop_word[11:0]);
    end
    chk("wrap.count", 32'(got_s.size()), 32'(3 * DEPTH));
    for (int i = 0; i < got_s.size(); i++)
      chk("wrap.seq", 32'(got_s[i]), 32'(i));

    // Reset mid-stream
    hard_reset();
    for (int i = 0; i < 4; i++)
      drive(1'b1, 4'h0, 2'b00, 6'h0, 4'h0, 4'(i), 12'h0, 1'b0, "mid.fill");
    idle(1'b1, "mid.pop");
    drive(1'b1, 4'h0, 2'b11, 6'h0, 4'h0, 4'h0, 12'h0, 1'b0, "mid.ill");
    chk("mid.level3", 32'(fill_level), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("mid.valid", 32'(instr_valid), 32'd0);
    chk("mid.level", 32'(fill_level), 32'd0);
    chk("mid.err", 32'(err_count), 32'd0);
    chk("mid.issued", 32'(issued_count), 32'd0);
    chk("mid.out", instr_out, 32'd0);
    chk("mid.ready", 32'(enc_ready), 32'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 4'h9, 2'b01, 6'h11, 4'h7, 4'h6, 12'h321, 1'b0, "mid.new");
    chk("mid.newhead", instr_out, 32'h95176321);

    // Randomised traffic against the model
    hard_reset();
    for (int i = 0; i < 2000; i++)
      drive($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom), 6'($urandom),
            4'($urandom), 4'($urandom), 12'($urandom), $urandom_range(0, 1) == 1, "rnd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_encoder_queue.md
Name: instr_encoder_queue

Overview:
- Producer-side counterpart to the instruction decoder.
- Accepts decoded-field requests (cond, op, funct, rn, rd, src2) over a valid/ready handshake and packs each into a 32-bit instruction word using the decoder's field layout.
- Rejects illegal opcodes and buffers legal words in a small FIFO.
- Presents words in order on a valid/ready output that feeds the decode path, instruction memory loaders and unit benches.

Parameters:
- WIDTH, 32, instruction word width. The field layout is fixed, so only 32 is legal.
- DEPTH, 4, FIFO entries. Must be a power of two and at least 2.
- CNT_W, 8, width of the error and issued counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- enc_valid  in  1  request fields are valid
- enc_ready  out  1  block can accept a request this cycle
- cond  in  4  condition field
- op  in  2  opcode: 00 data-processing, 01 memory, 10 branch, 11 illegal
- funct  in  6  function field
- rn  in  4  first source register
- rd  in  4  destination register
- src2  in  12  immediate / shifted-register field
- instr_valid  out  1  instr_out holds the head word
- instr_ready  in  1  consumer takes the head word
- instr_out  out  WIDTH  packed word
- fill_level  out  clog2(DEPTH)+1  current occupancy
- illegal_pulse  out  1  one-cycle pulse when a request is dropped
- err_count  out  CNT_W  dropped requests, saturating
- issued_count  out  CNT_W  words handed to the consumer, saturating

Behaviour:
- Reset values: enc_ready=1, instr_valid=0, instr_out=0, fill_level=0, illegal_pulse=0, err_count=0, issued_count=0. FIFO pointers are cleared.
- Packing: word = {cond[31:28], op[27:26], funct[25:20], rn[19:16], rd[15:12], src2[11:0]}. No field is modified.
- Input handshake: enc_ready = (fill_level != DEPTH). This is registered state only; there is no combinational path from instr_ready. A request is accepted on a rising edge where enc_valid and enc_ready are both 1.
- Legality check on an accepted request with op==11:
  - The handshake completes but the word is discarded and the FIFO is unchanged.
  - illegal_pulse=1 in the following cycle only.
  - err_count increments, saturating at all-ones.
- Legality check on an accepted request with op!=11: the word is written to the FIFO tail.
- Output handshake:
  - FIFO is show-ahead: instr_out always equals the head entry when instr_valid=1, and is held at its last value otherwise.
  - instr_valid = (fill_level != 0).
  - A pop occurs on an edge where instr_valid and instr_ready are both 1. issued_count increments on each pop, saturating.
- Latency: a legal word accepted at edge N is visible on instr_out/instr_valid after edge N when the FIFO was empty. There is no bypass around the FIFO.
- Simultaneous push and pop: allowed whenever enc_ready=1. fill_level is unchanged and order is preserved. When full, no push can occur, but a pop still proceeds, and enc_ready rises the next cycle.
- Illegal request together with a pop: fill_level decrements.
- Pointers wrap modulo DEPTH. fill_level never exceeds DEPTH or goes below 0.
- When empty, an instr_ready assertion has no effect.
- Reset mid-operation: all queued words are lost and all outputs return to their reset values immediately, independent of clk.
- Inputs are ignored while enc_valid=0.

Decomposition:
- Shared package (decode_pkg), also used by the decoder and benches:
  - op encodings OP_DP, OP_MEM, OP_BR, OP_ILLEGAL
  - field bit-position constants (COND_HI/LO, OP_HI/LO, FUNCT_HI/LO, RN_HI/LO, RD_HI/LO, SRC2_HI/LO)
  - a packed-struct typedef instr_fields_t matching the word layout
- One sub-module: instr_fifo, a parameterised show-ahead synchronous FIFO with async reset, push/pop, full/empty and level outputs. The top level holds the packing, legality check and counters.

Test Plan:
- Single ADD: after reset, enc_valid=1 for one cycle with cond=E, op=00, funct=101000, rn=1, rd=2, src2=005, and instr_ready=0 → instr_valid=1 on the next cycle, instr_out=32'hE2812005, fill_level=1.
- Fill and stall: DEPTH=4, instr_ready=0, five back-to-back requests → enc_ready=0 after the 4th accept, the 5th is held, fill_level=4. Then instr_ready=1 → words emerge in order, the 5th is accepted after the first pop, and issued_count=5 at the end.
- Illegal op: one request with op=11 → handshake completes, illegal_pulse high for exactly one cycle, err_count=1, instr_valid stays 0. 256 illegal requests with CNT_W=8 → err_count saturates at 8'hFF.
- Simultaneous push/pop: at fill_level=2, hold enc_valid=1 and instr_ready=1 for 6 cycles with distinct rd=0..5 → fill_level stays 2 and output rd sequence is the 2 preloaded words, then 0, 1, 2, 3.
- Wrap-around: 3×DEPTH push/pop cycles with incrementing src2 → every word is read exactly once, in order, and no duplicates appear at the pointer wrap.
- Reset mid-stream: assert reset asynchronously between edges with fill_level=3 → instr_valid=0, fill_level=0 and counters=0 immediately. After release, the first new request appears as the head word.
